// File: rtl/omsp_transpose_pkg.sv
// Shared constants and types for the omsp_transpose 4x4 transpose peripheral.
package omsp_transpose_pkg;

  localparam int DIM    = 4;
  localparam int NPAIRS = 6;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_IDX  = 2'd2;
  localparam logic [1:0] REG_DATA = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_IE    = 1;
  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  // Row-major flat index of element (row, col) in the 4x4 matrix.
  function automatic logic [3:0] elemIndex(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/omsp_transpose_pair_seq.sv
// Walks the six above-diagonal (i,j) pairs of a 4x4 matrix, one per advance.
module omsp_transpose_pair_seq
  import omsp_transpose_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_advance,
  output logic [1:0] o_i,
  output logic [1:0] o_j,
  output logic       o_last
);

  localparam logic [2:0] LAST_P = 3'(NPAIRS - 1);

  logic [2:0] r_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p <= '0;
    end else if (i_start) begin
      r_p <= '0;
    end else if (i_advance) begin
      r_p <= o_last ? 3'd0 : r_p + 3'd1;
    end
  end

  assign o_last = (r_p == LAST_P);

  always_comb begin
    o_i = 2'd0;
    o_j = 2'd1;
    case (r_p)
      3'd0: begin o_i = 2'd0; o_j = 2'd1; end
      3'd1: begin o_i = 2'd0; o_j = 2'd2; end
      3'd2: begin o_i = 2'd0; o_j = 2'd3; end
      3'd3: begin o_i = 2'd1; o_j = 2'd2; end
      3'd4: begin o_i = 2'd1; o_j = 2'd3; end
      3'd5: begin o_i = 2'd2; o_j = 2'd3; end
      default: begin o_i = 2'd0; o_j = 2'd1; end
    endcase
  end

endmodule

// File: rtl/omsp_transpose.sv
// openMSP430 peripheral: 16-word matrix window with an in-place 4x4 transpose engine.
module omsp_transpose
  import omsp_transpose_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR = 15'h0100,
  parameter int          DIM       = 4
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  output logic        irq_transpose
);

  localparam int NELEM = DIM * DIM;

  state_t      r_state;
  state_t      w_stateNext;
  logic        r_ie;
  logic        r_done;
  logic        r_irq;
  logic [3:0]  r_idx;
  logic [15:0] r_mem [NELEM];

  logic        w_sel, w_rd, w_wr, w_wrLo, w_busy;
  logic [1:0]  w_reg;
  logic        w_start, w_ieWr, w_doneClr, w_idxWr, w_dataWr, w_dataRd;
  logic        w_ieNext, w_doneNext, w_finish;
  logic [1:0]  w_i, w_j;
  logic        w_last;
  logic [3:0]  w_idxA, w_idxB;

  assign w_sel  = per_en & (per_addr[13:2] == BASE_ADDR[14:3]);
  assign w_reg  = per_addr[1:0];
  assign w_rd   = w_sel & (per_we == 2'b00);
  assign w_wr   = w_sel & (per_we != 2'b00);
  assign w_wrLo = w_sel & per_we[0];
  assign w_busy = (r_state == ST_RUN);

  // START, IDX and DATA are locked out while a transpose is running; IE and DONE are not.
  assign w_start   = w_wrLo & (w_reg == REG_CTRL) & per_din[CTRL_START] & ~w_busy;
  assign w_ieWr    = w_wrLo & (w_reg == REG_CTRL);
  assign w_doneClr = w_wrLo & (w_reg == REG_STAT) & per_din[STAT_DONE];
  assign w_idxWr   = w_wrLo & (w_reg == REG_IDX) & ~w_busy;
  assign w_dataWr  = w_wr & (w_reg == REG_DATA) & ~w_busy;
  assign w_dataRd  = w_rd & (w_reg == REG_DATA) & ~w_busy;

  omsp_transpose_pair_seq u_pairSeq (
    .clk       (mclk),
    .rst       (puc_rst),
    .i_start   (w_start),
    .i_advance (w_busy),
    .o_i       (w_i),
    .o_j       (w_j),
    .o_last    (w_last)
  );

  assign w_idxA = elemIndex(w_i, w_j);
  assign w_idxB = elemIndex(w_j, w_i);

  always_comb begin
    w_stateNext = r_state;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: if (w_start) w_stateNext = ST_RUN;
      ST_RUN: begin
        if (w_last) begin
          w_stateNext = ST_IDLE;
          w_finish    = 1'b1;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Completion beats a same-cycle DONE clear; the IRQ register sees next-cycle DONE/IE.
  assign w_ieNext   = w_ieWr ? per_din[CTRL_IE] : r_ie;
  assign w_doneNext = w_finish ? 1'b1 : (w_doneClr ? 1'b0 : r_done);

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      r_state <= ST_IDLE;
      r_ie    <= 1'b0;
      r_done  <= 1'b0;
      r_irq   <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_ie    <= w_ieNext;
      r_done  <= w_doneNext;
      r_irq   <= w_doneNext & w_ieNext;
      if (w_idxWr) begin
        r_idx <= per_din[3:0];
      end else if (w_dataWr | w_dataRd) begin
        r_idx <= r_idx + 4'd1;
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      for (int k = 0; k < NELEM; k++) begin
        r_mem[k] <= '0;
      end
    end else if (w_busy) begin
      r_mem[w_idxA] <= r_mem[w_idxB];
      r_mem[w_idxB] <= r_mem[w_idxA];
    end else if (w_dataWr) begin
      if (per_we[0]) r_mem[r_idx][7:0]  <= per_din[7:0];
      if (per_we[1]) r_mem[r_idx][15:8] <= per_din[15:8];
    end
  end

  always_comb begin
    per_dout = 16'h0000;
    if (w_rd) begin
      case (w_reg)
        REG_CTRL: per_dout = {14'd0, r_ie, 1'b0};
        REG_STAT: per_dout = {14'd0, r_done, w_busy};
        REG_IDX:  per_dout = {12'd0, r_idx};
        REG_DATA: per_dout = w_busy ? 16'h0000 : r_mem[r_idx];
        default:  per_dout = 16'h0000;
      endcase
    end
  end

  assign irq_transpose = r_irq;

endmodule

// File: doc/omsp_transpose.md
# omsp_transpose

Memory-mapped 4x4 matrix-transpose accelerator and responder on the openMSP430 peripheral bus. Software loads 16 words row-major through a data window, starts an in-place transpose, and reads the result back in row-major order. The block sits beside the GPIO, timer and UART peripherals: its per_dout is ORed into the CPU per_dout bus, and its interrupt is wired to a free irq_bus vector.

## Interface
- BASE_ADDR, 15'h0100: byte base address of the 8-byte register block; must be 8-byte aligned.
- DIM, 4: matrix dimension. Only 4 is supported. The element count is DIM*DIM = 16.
- mclk  in  1  main system clock; the only clock.
- puc_rst  in  1  reset, synchronous, active-high.
- per_addr  in  14  peripheral word address.
- per_din  in  16  peripheral write data.
- per_en  in  1  peripheral access strobe, active-high.
- per_we  in  2  byte write enables; 2'b00 means a read.
- per_dout  out  16  read data; 16'h0000 when the block is not selected.
- irq_transpose  out  1  level interrupt = DONE & IE.

## Operation
- Select: sel = per_en & (per_addr[13:2] == BASE_ADDR[14:3]). The register is chosen by per_addr[1:0].
- Register map:
  - CTRL (+0): bit0 START, write-1 pulse, reads 0; bit1 IE.
  - STAT (+2): bit0 BUSY (RO); bit1 DONE, write-1 clears.
  - IDX (+4): bits[3:0] element pointer.
  - DATA (+6): matrix window.
- Only bits shown are defined. Other bits read 0 and writes to them are ignored.
- For CTRL, STAT and IDX, only the low byte is used, and only when per_we[0] = 1.
- DATA write (any per_we != 0, not BUSY):
  - The byte lanes enabled by per_we update mem[IDX].
  - IDX then increments modulo 16 (15 wraps to 0).
- DATA read (per_we = 0, not BUSY):
  - per_dout = mem[IDX], combinational in the access cycle.
  - IDX increments at the end of that cycle.
- While BUSY:
  - Writes to DATA and IDX are ignored.
  - DATA reads return 0 and do not increment IDX.
  - START is ignored.
  - CTRL.IE and STAT.DONE remain writable.
- FSM states: IDLE and RUN.
  - IDLE -> RUN on a START write, with the pair counter p = 0.
  - In RUN, each cycle swaps mem[i*4+j] with mem[j*4+i] for pair p.
  - Pair order for p = 0..5: (0,1) (0,2) (0,3) (1,2) (1,3) (2,3).
  - p increments after each swap. After the p = 5 swap, the FSM returns to IDLE and sets DONE.
- BUSY = (state == RUN).
- Diagonal elements are never touched.
- Simultaneous events:
  - Completion and a DONE-clear write in the same cycle: DONE ends at 1 (set wins).
  - START written together with IE: both take effect.

## Timing
- Reset values: per_dout = 0, irq_transpose = 0, state = IDLE, IDX = 0, IE = 0, DONE = 0, and all 16 mem words = 0.
- Reset applied mid-RUN aborts within that cycle. The matrix is cleared, not partially transposed.
- Reads have zero wait states: per_dout is valid in the same cycle per_en is high.
- Write effects are visible from the next cycle.
- Transpose latency, with START written in cycle T:
  - BUSY = 1 in cycles T+1 .. T+6.
  - DONE = 1 and irq_transpose = 1 (if IE) from T+7.
  - BUSY = 0 from T+7.
- irq_transpose stays high until DONE is cleared or IE is cleared, with a 1-cycle registered update.

## Structure
- Package omsp_transpose_pkg holds:
  - register offsets: CTRL = 0, STAT = 1, IDX = 2, DATA = 3 (word offsets);
  - CTRL and STAT bit positions;
  - the state enum {IDLE, RUN};
  - DIM and NPAIRS = 6.
- Sub-module omsp_transpose_pair_seq:
  - counter p over 0..5 with combinational (i,j) outputs;
  - start/advance inputs and a last output.
- The top level holds the bus decode, registers, the 16x16-bit storage and the FSM.

## Test plan
- Reset: after puc_rst is held for 2 cycles, all registers, IDX, per_dout and irq_transpose read 0. An unselected address returns 0.
- Load/readback: write IDX = 0, then write DATA 16 times with value k at step k. Reading DATA 16 times returns 0..15. IDX wraps to 0.
- Transpose: load as above, write CTRL = 0x0003. Required response:
  - BUSY is high for exactly 6 cycles.
  - DONE and the IRQ are set at T+7.
  - Readback is 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15.
- Busy guard: during RUN, write DATA = 0xBEEF and IDX = 5, and issue a second START. The result is unchanged, IDX is unchanged, and BUSY is still 6 cycles total.
- Byte lanes and DONE race:
  - Write DATA with per_we = 2'b10 and value 0xAB00 over the existing value 0x0012. The stored value is 0xAB12.
  - Write STAT = 0x02 in cycle T+6. DONE still reads 1 at T+7.
- Reset mid-RUN: assert puc_rst at T+3. The state is IDLE and all mem = 0 on the next cycle, and no IRQ is raised.
